// File: rtl/cmd_seq_arb_if.sv
// Client/sequencer handshake bundle for cmd_seq_arb.
// The slave modport is the arbiter; the master side is the client and sequencer logic.
interface cmd_seq_arb_if #(
  parameter int REQUESTERS = 4
);
  localparam int IW = $clog2(REQUESTERS);

  logic [REQUESTERS-1:0] REQ;
  logic [REQUESTERS-1:0] GRANT;
  logic [REQUESTERS-1:0] DONE;
  logic [REQUESTERS-1:0] ERR;
  logic [IW-1:0]         GRANT_ID;
  logic                  CMD_READY;
  logic                  CMD_EXT_START_ENABLE;
  logic                  CMD_EXT_START_FLAG;
  logic                  BUSY;

  modport slave (
    input  REQ, CMD_READY, CMD_EXT_START_ENABLE,
    output GRANT, DONE, ERR, GRANT_ID, CMD_EXT_START_FLAG, BUSY
  );

  modport master (
    output REQ, CMD_READY, CMD_EXT_START_ENABLE,
    input  GRANT, DONE, ERR, GRANT_ID, CMD_EXT_START_FLAG, BUSY
  );
endinterface

// File: rtl/cmd_seq_arb.sv
// Round-robin arbiter sharing one command sequencer: start pulse, busy/idle tracking, gap and timeout.
// Define CMD_SEQ_ARB_PRIO_EN to make client 0 win every arbitration it takes part in.
module cmd_seq_arb #(
  parameter  int REQUESTERS     = 4,
  parameter  int GAP_CYCLES     = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int CW             = 11,
  localparam int IW             = $clog2(REQUESTERS)
) (
  input  logic          BUS_CLK,
  input  logic          BUS_RST,
  cmd_seq_arb_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  localparam logic [IW:0]   NREQ     = (IW+1)'(REQUESTERS);
  localparam logic [CW:0]   TO_LAST  = (CW+1)'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES);

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         gid_q, gid_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [REQUESTERS-1:0] done_q, done_d;
  logic [REQUESTERS-1:0] err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [IW-1:0] win;
  logic          win_vld;

  // Walk from the farthest candidate back to ptr+1 so the nearest requester is written last.
  always_comb begin
    logic [IW:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = REQUESTERS; i >= 1; i--) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.REQ[idx[IW-1:0]]) begin
        win     = idx[IW-1:0];
        win_vld = 1'b1;
      end
    end
`ifdef CMD_SEQ_ARB_PRIO_EN
    if (bus.REQ[0]) begin
      win     = '0;
      win_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld && bus.CMD_READY && bus.CMD_EXT_START_ENABLE) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          gid_d        = win;
`ifdef CMD_SEQ_ARB_PRIO_EN
          if (!bus.REQ[0]) ptr_d = win;
`else
          ptr_d        = win;
`endif
          state_d      = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.CMD_READY) begin
          state_d = WAIT_DONE;
        end else if ({1'b0, cnt_q} + (CW+1)'(1) >= TO_LAST) begin
          err_d   = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.CMD_READY) begin
          done_d  = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.GRANT              = grant_q;
  assign bus.DONE               = done_q;
  assign bus.ERR                = err_q;
  assign bus.GRANT_ID           = gid_q;
  assign bus.CMD_EXT_START_FLAG = (state_q == START);
  assign bus.BUSY               = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_seq_arb.sv
// Randomized bench for cmd_seq_arb: a transaction-level model predicts each sequence
// (winner, start cycle, done/err cycle) into a queue that a negedge monitor checks.
module tb_cmd_seq_arb;
  localparam int R   = 4;
  localparam int GAP = 8;
  localparam int TO  = 16;
  localparam int CW  = 11;

  logic BUS_CLK = 1'b0;
  logic BUS_RST = 1'b1;

  cmd_seq_arb_if #(.REQUESTERS(R)) bus ();

  cmd_seq_arb #(
    .REQUESTERS(R), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CW(CW)
  ) dut (
    .BUS_CLK(BUS_CLK),
    .BUS_RST(BUS_RST),
    .bus    (bus)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int cyc = 0;
  always @(posedge BUS_CLK) cyc <= cyc + 1;

  typedef struct {
    int id;
    int start;
    int pulse;
    bit err;
  } rec_t;

  rec_t q[$];
  int   vectors = 0, miscompares = 0;
  bit   mon_on = 1'b0;
  int   epoch = 0;

  // Reference model state: one sequence in flight at most, timing from timestamps.
  logic [R-1:0] req = '0;
  int  blk[R];
  int  ptr_m = 0;
  bit  act = 1'b0;
  int  s_c = 0, k_c = 0, l_c = 0, pulse_c = 0, id_c = 0;
  int  free_at = 0;
  int  force_k = 0, force_l = 0;
  logic rdy = 1'b1, en = 1'b1;

  function automatic int pick(logic [R-1:0] r, int p);
`ifdef CMD_SEQ_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int i = 1; i <= R; i++) begin
      if (r[(p + i) % R]) return (p + i) % R;
    end
    return 0;
  endfunction

  task automatic drive_cycle(int raise_pct, bit allow_block);
    int c;
    c = cyc;
    if (act && c == pulse_c + 1) begin
      req[id_c] = 1'b0;
      blk[id_c] = c;
      act = 1'b0;
    end
    for (int i = 0; i < R; i++) begin
      if (act && i == id_c) begin
        if (c > s_c && $urandom_range(31) == 0) req[i] = 1'b0;
      end else if (!req[i] && c > blk[i] && int'($urandom_range(99)) < raise_pct) begin
        req[i] = 1'b1;
      end
    end
    // Sequencer: idle flag follows the plan while a sequence is live, otherwise random blocking.
    if (act && c > s_c && c < pulse_c)
      rdy = !(c >= s_c + k_c && c < s_c + k_c + l_c);
    else
      rdy = allow_block ? ($urandom_range(7) != 0) : 1'b1;
    en = allow_block ? ($urandom_range(7) != 0) : 1'b1;
    if (!act && c >= free_at && req != '0 && rdy && en && !BUS_RST) begin
      id_c = pick(req, ptr_m);
`ifdef CMD_SEQ_ARB_PRIO_EN
      if (!req[0]) ptr_m = id_c;
`else
      ptr_m = id_c;
`endif
      s_c = c + 1;
      if (force_k != 0) begin
        k_c = force_k; l_c = force_l; force_k = 0;
      end else if ($urandom_range(4) == 0) begin
        k_c = TO; l_c = 0;
      end else begin
        k_c = int'($urandom_range(4, 1));
        l_c = int'($urandom_range(12, 1));
      end
      pulse_c = (k_c <= TO - 1) ? s_c + k_c + l_c + 1 : s_c + TO;
      q.push_back('{id_c, s_c, pulse_c, (k_c > TO - 1)});
      act = 1'b1;
      free_at = pulse_c + GAP + 1;
    end
    bus.REQ = req;
    bus.CMD_READY = rdy;
    bus.CMD_EXT_START_ENABLE = en;
  endtask

  task automatic tick(int raise_pct, bit allow_block);
    @(posedge BUS_CLK);
    #1;
    drive_cycle(raise_pct, allow_block);
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: expected outputs each cycle derive from the front scoreboard record.
  int   exp_gid = 0, last_pulse = -1000, seen_epoch = 0;
  rec_t r;
  bit   have, es, eb;
  logic [31:0] eg, ed, ee;
  initial forever begin
    @(negedge BUS_CLK);
    if (mon_on) begin
      if (epoch != seen_epoch) begin
        exp_gid = 0; last_pulse = -1000; seen_epoch = epoch;
      end
      have = (q.size() > 0);
      if (have) r = q[0];
      es = have && cyc == r.start;
      if (es) exp_gid = r.id;
      eg = (have && cyc >= r.start && cyc < r.pulse) ? (32'd1 << r.id) : 32'd0;
      ed = (have && cyc == r.pulse && !r.err) ? (32'd1 << r.id) : 32'd0;
      ee = (have && cyc == r.pulse &&  r.err) ? (32'd1 << r.id) : 32'd0;
      eb = (have && cyc >= r.start) || (cyc <= last_pulse + GAP);
      chk("GRANT",    32'(bus.GRANT),              eg);
      chk("START",    32'(bus.CMD_EXT_START_FLAG), 32'(es));
      chk("DONE",     32'(bus.DONE),               ed);
      chk("ERR",      32'(bus.ERR),                ee);
      chk("BUSY",     32'(bus.BUSY),               32'(eb));
      chk("GRANT_ID", 32'(bus.GRANT_ID),           32'(exp_gid));
      if (have && cyc >= r.pulse) begin
        last_pulse = r.pulse;
        void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < R; i++) blk[i] = -1;
    bus.REQ = '0;
    bus.CMD_READY = 1'b1;
    bus.CMD_EXT_START_ENABLE = 1'b1;
    @(posedge BUS_CLK); #1;
    mon_on = 1'b1;
    @(posedge BUS_CLK); #1;
    BUS_RST = 1'b0;
    free_at = cyc;
    drive_cycle(0, 1'b0);
    while (cyc < 9) tick(0, 1'b0);

    // Lone request from client 2 at cycle 10, sequencer busy 2 cycles after start for 20.
    @(posedge BUS_CLK); #1;
    req[2] = 1'b1; force_k = 2; force_l = 20;
    drive_cycle(0, 1'b0);
    repeat (40) tick(0, 1'b0);

    repeat (2000) tick(10, 1'b1);
    repeat (400) tick(100, 1'b0);

    // Drain, then reset in the middle of a sequence.
    for (int n = 0; n < 3000 && (act || req != '0 || cyc < free_at); n++) tick(0, 1'b0);
    if (act || req != '0) begin
      miscompares++;
      $display("FAIL drain cyc=%0d got=busy expected=idle", cyc);
    end
    @(posedge BUS_CLK); #1;
    req[2] = 1'b1; force_k = 2; force_l = 20;
    drive_cycle(0, 1'b0);
    repeat (5) tick(0, 1'b0);
    BUS_RST = 1'b1;
    @(posedge BUS_CLK); #1;
    BUS_RST = 1'b0;
    q.delete();
    epoch++;
    act = 1'b0; ptr_m = 0; free_at = cyc;
    req = 4'b0011;
    drive_cycle(0, 1'b0);
    repeat (120) tick(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
